// File: rtl/alu_request_scheduler.sv
// Shares one combinational ALU among four requesters: round-robin grant, registered operands, tagged response.
// Build option: define ALU_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module alu_request_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [11:0] req_a,
  input  logic [11:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [3:0]  req_ready,
  output logic [2:0]  alu_a,
  output logic [2:0]  alu_b,
  output logic [1:0]  alu_sel,
  input  logic [5:0]  alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [5:0]  rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [1:0] cur_id;
  logic [1:0] winner;
  logic       any_valid;
  logic       grant_en;
  logic       accept;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  always_comb begin
    winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) winner = 2'(i);
    end
  end
`else
  logic [1:0] last_id;
  logic [1:0] idx;
  logic       found;

  // Search starts just after the previous winner and wraps 3 -> 0.
  always_comb begin
    winner = 2'd0;
    idx    = 2'd0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_id + 2'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  assign any_valid = |req_valid;
  // A new grant is possible in IDLE, or in DONE when the response retires this edge.
  assign grant_en  = (state == IDLE) || ((state == DONE) && rsp_ready);
  assign accept    = grant_en && any_valid;
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_id     <= 2'd0;
      alu_a      <= 3'd0;
      alu_b      <= 3'd0;
      alu_sel    <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_result <= 6'd0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_id    <= 2'd3;
`endif
    end else begin
      if (accept) begin
        alu_a   <= req_a[3*winner +: 3];
        alu_b   <= req_b[3*winner +: 3];
        alu_sel <= req_sel[2*winner +: 2];
        cur_id  <= winner;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        last_id <= winner;
`endif
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_request_scheduler.md
# alu_request_scheduler

Shares a single combinational `arithmetic_logic_unit` between four independent requesters. Each requester presents an operation (A, B, sel) with a valid/ready handshake. The block arbitrates round-robin, registers the winner's operands onto the ALU ports, captures the 6-bit result one cycle later, and returns it tagged with the requester ID on a valid/ready response channel. It sits between the tile's request sources and the ALU instance, inside `tt_um_arithmetic_logic_unit`.

## Interface
- No parameters. Requester count is fixed at 4, operands at 3 bits, sel at 2 bits, result at 6 bits.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 4: requester i has an operation pending.
- `req_a` in 12: operand A of requester i, in `req_a[3i+2:3i]`.
- `req_b` in 12: operand B of requester i, in `req_b[3i+2:3i]`.
- `req_sel` in 8: ALU select of requester i, in `req_sel[2i+1:2i]`.
- `req_ready` out 4: one-hot grant. Requester i's operation is accepted in any cycle where `req_valid[i] & req_ready[i]`.
- `alu_a` out 3: registered operand A to the ALU.
- `alu_b` out 3: registered operand B to the ALU.
- `alu_sel` out 2: registered select to the ALU.
- `alu_result` in 6: combinational ALU result.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 2: index of the requester that owns `rsp_result`.
- `rsp_result` out 6: captured ALU result.
- `busy` out 1: high in EXEC or DONE.

## Operation
- FSM has three states: IDLE, EXEC and DONE.
- **IDLE**
  - If any `req_valid` is high, assert `req_ready` for the winner.
  - On the clock edge, latch the winner's A/B/sel into `alu_a`/`alu_b`/`alu_sel` and its index into `cur_id`, then go to EXEC.
- **EXEC**
  - `req_ready` is 0.
  - On the clock edge, `rsp_result <= alu_result`, `rsp_id <= cur_id`, `rsp_valid <= 1`, then go to DONE.
- **DONE**
  - If `rsp_ready` is 0, hold all outputs stable and keep `req_ready` at 0.
  - If `rsp_ready` is 1 and a request is valid, the response retires. In the same cycle, arbitrate and accept a new request as in IDLE, then go to EXEC with `rsp_valid` going to 0.
  - If `rsp_ready` is 1 and no request is valid, clear `rsp_valid` and go to IDLE.
- **Arbitration** (round-robin)
  - Search order starts at `last_id+1` and wraps modulo 4: 3 -> 0.
  - `last_id` updates to the winner only on an accepted request.
  - `req_ready` depends only on the state, `req_valid`, `last_id` and (in DONE) `rsp_ready`. It never depends on `req_a`, `req_b` or `req_sel`.
  - At most one `req_ready` bit is high in any cycle.
- **Request handshake**
  - Requesters must hold valid and payload until accepted.
  - Dropping `req_valid` before acceptance withdraws the request; no state is affected.
- **ALU ports**
  - `alu_a`, `alu_b` and `alu_sel` change only on acceptance.
  - Between operations they keep their last values.
- **Reset mid-operation**
  - Asserting `rst_n` low in any state returns the block to IDLE immediately.
  - Any in-flight operation and any unconsumed response are discarded.

## Timing
- Reset values:
  - State IDLE, `last_id`=3 (requester 0 wins first).
  - `req_ready`=0, `alu_a`=0, `alu_b`=0, `alu_sel`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `busy`=0.
- Latency: a request accepted at edge N gives `alu_*` valid after N, `rsp_valid`=1 after N+1, and the earliest response retirement at edge N+2.
- Throughput: one operation per 2 cycles with `rsp_ready` tied high.
- `req_ready` and `rsp_valid` are never high for the same requester's in-flight operation.
- DONE with `rsp_ready`=1 and a valid request is a simultaneous retire-and-accept. Both handshakes complete on the same edge, with no bubble cycle in IDLE.

## Configuration
- `ALU_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority. The lowest index with `req_valid` wins, and `last_id` is not implemented.
  - Undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset, then `req_valid`=0001 with A=3, B=5, sel=00 -> `req_ready`=0001 one cycle. `alu_a`=3, `alu_b`=5, `alu_sel`=0 next cycle. `rsp_valid`=1 with `rsp_id`=0 and `rsp_result` equal to the bench ALU model output two cycles after acceptance.
- `req_valid`=1111 held, `rsp_ready`=1 -> grant order 0,1,2,3,0 on successive accepts, one accept every 2 cycles. With `ALU_SCHED_FIXED_PRIO_EN` defined, the order is 0,0,0,…
- Backpressure: `rsp_ready`=0 for 5 cycles while in DONE with `req_valid`=0010 -> `req_ready` stays 0 and `rsp_result`/`rsp_id` stay stable. Raising `rsp_ready` gives retire and accept of requester 1 on the same edge.
- Withdrawal: `req_valid[2]` pulsed high for one cycle while the block is in EXEC -> no grant to requester 2, no response, and `last_id` unchanged.
- Reset asserted during EXEC (`req_valid`=0100 accepted) -> `rsp_valid`, `busy` and `req_ready` are 0 immediately. After release, requester 0 wins first when all requesters are valid.
